// File: rtl/ram_arbiter_2p_if.sv
// Two requester ports plus the single-port RAM side, shared by the arbiter and its environment.
interface ram_arbiter_2p_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  // requesters and the RAM model
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_q,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, ram_data, ram_addr, ram_we
  );

  // arbiter
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_q,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, ram_data, ram_addr, ram_we
  );
endinterface

// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter in front of a single-port synchronous RAM, one access per clock.
// Define RAM_ARB_FIXED_PRIO_EN to give A fixed priority instead of round-robin.
module ram_arbiter_2p #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  ram_arbiter_2p_if.slave  bus
);

  logic gnt_a_c;
  logic gnt_b_c;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign gnt_a_c = !rst && bus.a_req;
`else
  // last_b = 1 means B was granted most recently; reset value lets A win first contention
  logic last_b;

  assign gnt_a_c = !rst && bus.a_req && (!bus.b_req || last_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (gnt_a_c || gnt_b_c) begin
      last_b <= gnt_b_c;
    end
  end
`endif

  assign gnt_b_c = !rst && bus.b_req && !gnt_a_c;

  assign bus.a_gnt = gnt_a_c;
  assign bus.b_gnt = gnt_b_c;

  // RAM port mux: zeros when idle
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = ADDR_WIDTH'(0);
    bus.ram_data = DATA_WIDTH'(0);
    if (gnt_a_c) begin
      bus.ram_we   = bus.a_we;
      bus.ram_addr = bus.a_addr;
      bus.ram_data = bus.a_wdata;
    end else if (gnt_b_c) begin
      bus.ram_we   = bus.b_we;
      bus.ram_addr = bus.b_addr;
      bus.ram_data = bus.b_wdata;
    end
  end

  // RAM read latency is one clock, so rvalid tracks a granted read by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
    end else begin
      bus.a_rvalid <= gnt_a_c && !bus.a_we;
      bus.b_rvalid <= gnt_b_c && !bus.b_we;
    end
  end

  assign bus.a_rdata = bus.ram_q;
  assign bus.b_rdata = bus.ram_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: directed scenarios plus randomized traffic vs. a reference model.
module tb_ram_arbiter_2p;

  typedef struct {
    logic       req;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
  } rq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ram_arbiter_2p_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();

  ram_arbiter_2p #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM, read-before-write
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_addr];
  end

  // reference model state
  logic [7:0] ref_mem   [64];
  bit         ref_known [64];
  bit         last_was_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input rq_t a, input rq_t b);
    bus.a_req = a.req; bus.a_we = a.we; bus.a_addr = a.addr; bus.a_wdata = a.wdata;
    bus.b_req = b.req; bus.b_we = b.we; bus.b_addr = b.addr; bus.b_wdata = b.wdata;
  endtask

  function automatic rq_t mk(input logic req, input logic we, input logic [5:0] addr, input logic [7:0] wd);
    rq_t r;
    r.req = req; r.we = we; r.addr = addr; r.wdata = wd;
    return r;
  endfunction

  // one clock of traffic; entered and left just after a falling edge
  task automatic step(input rq_t a, input rq_t b, output logic ga, output logic gb);
    logic       ea, eb, rva, rvb, known;
    logic [7:0] rd;
    rq_t        w;
    drive(a, b);
    #1;
    if (a.req && b.req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      ea = 1'b1;
`else
      ea = last_was_b;
`endif
      eb = !ea;
    end else begin
      ea = a.req;
      eb = b.req;
    end
    check("a_gnt", 32'(bus.a_gnt), 32'(ea));
    check("b_gnt", 32'(bus.b_gnt), 32'(eb));
    w = ea ? a : (eb ? b : mk(1'b0, 1'b0, 6'd0, 8'd0));
    check("ram_we",   32'(bus.ram_we),   32'(w.we));
    check("ram_addr", 32'(bus.ram_addr), 32'(w.addr));
    check("ram_data", 32'(bus.ram_data), 32'(w.wdata));
    rva = ea && !a.we;
    rvb = eb && !b.we;
    rd = ref_mem[w.addr];
    known = ref_known[w.addr];
    if ((ea || eb) && w.we) begin
      ref_mem[w.addr] = w.wdata;
      ref_known[w.addr] = 1'b1;
    end
    if (ea || eb) last_was_b = eb;
    @(posedge clk);
    #1;
    check("a_rvalid", 32'(bus.a_rvalid), 32'(rva));
    check("b_rvalid", 32'(bus.b_rvalid), 32'(rvb));
    if (rva && known) check("a_rdata", 32'(bus.a_rdata), 32'(rd));
    if (rvb && known) check("b_rdata", 32'(bus.b_rdata), 32'(rd));
    @(negedge clk);
    ga = ea;
    gb = eb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(1'b0, 1'b0, 6'd0, 8'd0), mk(1'b0, 1'b0, 6'd0, 8'd0));
    @(posedge clk);
    #1;
    check("rst_a_gnt",    32'(bus.a_gnt),    32'd0);
    check("rst_b_gnt",    32'(bus.b_gnt),    32'd0);
    check("rst_ram_we",   32'(bus.ram_we),   32'd0);
    check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_was_b = 1'b1;
  endtask

  initial begin
    logic ga, gb;
    rq_t  idle, pa, pb;
    idle = mk(1'b0, 1'b0, 6'd0, 8'd0);
    for (int i = 0; i < 64; i++) ref_known[i] = 1'b0;
    drive(idle, idle);
    @(negedge clk);
    do_reset();

    // fill memory back-to-back from A
    for (int i = 0; i < 64; i++) step(mk(1'b1, 1'b1, 6'(i), 8'($urandom)), idle, ga, gb);

    // A writes 1/2/3 then reads them back
    for (int i = 0; i < 3; i++) step(mk(1'b1, 1'b1, 6'(i), 8'(i + 1)), idle, ga, gb);
    for (int i = 0; i < 3; i++) begin
      step(mk(1'b1, 1'b0, 6'(i), 8'h00), idle, ga, gb);
      check("a_rdata_seq", 32'(bus.a_rdata), 32'(i + 1));
    end

    // contention right after reset
    do_reset();
    for (int i = 0; i < 4; i++) step(mk(1'b1, 1'b0, 6'd0, 8'h00), mk(1'b1, 1'b0, 6'd1, 8'h00), ga, gb);
    step(idle, mk(1'b1, 1'b0, 6'd1, 8'h00), ga, gb);

    // read followed by write to same address returns old data
    step(mk(1'b1, 1'b1, 6'd5, 8'h11), idle, ga, gb);
    step(mk(1'b1, 1'b0, 6'd5, 8'h00), idle, ga, gb);
    check("rbw_old", 32'(bus.a_rdata), 32'h11);
    step(idle, mk(1'b1, 1'b1, 6'd5, 8'h22), ga, gb);
    step(mk(1'b1, 1'b0, 6'd5, 8'h00), idle, ga, gb);
    check("rbw_new", 32'(bus.a_rdata), 32'h22);

    // reset lands in the cycle B's read is granted
    drive(idle, mk(1'b1, 1'b0, 6'd3, 8'h00));
    #1;
    check("pre_rst_b_gnt", 32'(bus.b_gnt), 32'd1);
    rst = 1'b1;
    #1;
    check("in_rst_b_gnt",  32'(bus.b_gnt),  32'd0);
    check("in_rst_ram_we", 32'(bus.ram_we), 32'd0);
    @(posedge clk);
    #1;
    check("in_rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    @(negedge clk);
    drive(idle, idle);
    rst = 1'b0;
    last_was_b = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    @(negedge clk);
    step(mk(1'b1, 1'b0, 6'd2, 8'h00), mk(1'b1, 1'b0, 6'd3, 8'h00), ga, gb);
    check("post_rst_first_a", 32'(ga), 32'd1);

    // idle cycles
    for (int i = 0; i < 3; i++) step(idle, idle, ga, gb);

    // randomized traffic; a waiting request is held unchanged until granted
    pa = idle;
    pb = idle;
    for (int i = 0; i < 400; i++) begin
      if (!pa.req && ($urandom_range(0, 9) < 6))
        pa = mk(1'b1, 1'($urandom), 6'($urandom), 8'($urandom));
      if (!pb.req && ($urandom_range(0, 9) < 6))
        pb = mk(1'b1, 1'($urandom), 6'($urandom), 8'($urandom));
      step(pa, pb, ga, gb);
      if (ga) pa = idle;
      if (gb) pb = idle;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, the RAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the RAM data width.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 a_req  input  1  requester A has an access pending.
REQ-006 a_we  input  1  requester A access type: 1 = write, 0 = read.
REQ-007 a_addr  input  ADDR_WIDTH  requester A word address.
REQ-008 a_wdata  input  DATA_WIDTH  requester A write data.
REQ-009 a_gnt  output  1  requester A access issued to the RAM this cycle (combinational).
REQ-010 a_rvalid  output  1  requester A read data valid (registered).
REQ-011 a_rdata  output  DATA_WIDTH  requester A read data.
REQ-012 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  SHALL mirror the A ports for requester B.
REQ-013 ram_data  output  DATA_WIDTH  write data to the single-port RAM.
REQ-014 ram_addr  output  ADDR_WIDTH  address to the single-port RAM.
REQ-015 ram_we  output  1  write enable to the single-port RAM.
REQ-016 ram_q  input  DATA_WIDTH  RAM read data, valid one clock after the address is sampled.

Function
REQ-017 At most one of a_gnt and b_gnt SHALL be high in any cycle; a grant is issued only to a requester whose req is high.
REQ-018 Round-robin arbitration: if only one requester asserts req, that requester is granted; if both assert req, the requester not granted most recently is granted.
REQ-019 The last-grant register SHALL update on every clock edge where a grant is issued and hold otherwise.
REQ-020 In a granted cycle, ram_addr, ram_data and ram_we SHALL equal the granted requester's addr, wdata and we, combinationally.
REQ-021 With no grant, ram_we SHALL be 0, ram_addr 0 and ram_data 0.
REQ-022 A granted read SHALL set the owner's rvalid high for exactly the following cycle, with rdata = ram_q in that cycle; the other requester's rvalid stays 0.
REQ-023 A granted write SHALL never assert rvalid.
REQ-024 a_rdata and b_rdata SHALL be driven from ram_q, and are don't-care when the matching rvalid is 0.
REQ-025 Back-to-back grants SHALL be supported every cycle; throughput is one access per clock with no bubble between requesters.
REQ-026 A requester holding req high while not granted SHALL keep addr, we and wdata stable; the arbiter drops nothing, and the request waits until granted.
REQ-027 A read followed next cycle by a write to the same address SHALL return the pre-write data to the reader.

Reset
REQ-028 While rst is high, a_rvalid, b_rvalid, a_gnt, b_gnt and ram_we SHALL be 0, and the last-grant register SHALL indicate B, so A wins the first contention.
REQ-029 A read granted in the cycle rst asserts SHALL NOT produce rvalid after reset releases.
REQ-030 Arbitration SHALL resume on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro RAM_ARB_FIXED_PRIO_EN: when defined, contention SHALL always be granted to A, and the last-grant register SHALL be omitted.
REQ-032 When RAM_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-018 applies.

Verification
REQ-033 A writes 0x01/0x02/0x03 to addresses 0/1/2 in 3 cycles, then reads them -> a_gnt high every cycle; a_rvalid one cycle after each read, with a_rdata 0x01, 0x02, 0x03.
REQ-034 A and B both hold read requests (A addr 0, B addr 1) for 4 cycles after reset -> grants are A, B, A, B; rvalid alternates with matching data.
REQ-035 Same contention with RAM_ARB_FIXED_PRIO_EN defined -> a_gnt high for all 4 cycles and b_gnt stays 0 until a_req drops.
REQ-036 A reads address 5 (holding 0x11) while B writes 0x22 to address 5 in the next cycle -> a_rdata = 0x11; a later read returns 0x22.
REQ-037 rst asserted in the cycle B's read is granted -> b_rvalid stays 0, and after release the first A/B contention is granted to A.
REQ-038 No requests for 3 cycles -> ram_we = 0, ram_addr = 0, and both rvalid stay 0.
